// File: rtl/control_pipeline_if.sv
// Control bundle between the ID decoder, the EX branch unit and the EX/MEM/WB datapath muxes.
// The slave side is the control pipeline; the master side drives decoder outputs and consumes stage controls.
// No handshake: every signal is valid each cycle, and the stall and flush outputs carry the backpressure.
interface control_pipeline_if #(
  parameter int REG_BITS = 5
);
  // ID-stage decoder outputs
  logic                ALUASrc;
  logic                ALUBSrc;
  logic [3:0]          ALUOp;
  logic [4:0]          BrOp;
  logic                DMWr;
  logic [2:0]          DMCtrl;
  logic                RUWr;
  logic [1:0]          RUDATAWrSrc;
  logic [REG_BITS-1:0] Rs1;
  logic [REG_BITS-1:0] Rs2;
  logic [REG_BITS-1:0] Rd;
  logic                Rs1Used;
  logic                Rs2Used;
  // EX-stage branch resolution
  logic                BranchTaken;
  // Stage controls
  logic                ExALUASrc;
  logic                ExALUBSrc;
  logic [3:0]          ExALUOp;
  logic [4:0]          ExBrOp;
  logic                MemDMWr;
  logic [2:0]          MemDMCtrl;
  logic                WbRUWr;
  logic [1:0]          WbRUDATAWrSrc;
  logic [REG_BITS-1:0] WbRd;
  // Hazard controls
  logic                Stall;
  logic                FlushIFID;
  logic [1:0]          ForwardA;
  logic [1:0]          ForwardB;

  modport slave (
    input  ALUASrc, ALUBSrc, ALUOp, BrOp, DMWr, DMCtrl, RUWr, RUDATAWrSrc,
           Rs1, Rs2, Rd, Rs1Used, Rs2Used, BranchTaken,
    output ExALUASrc, ExALUBSrc, ExALUOp, ExBrOp, MemDMWr, MemDMCtrl,
           WbRUWr, WbRUDATAWrSrc, WbRd, Stall, FlushIFID, ForwardA, ForwardB
  );

  modport master (
    output ALUASrc, ALUBSrc, ALUOp, BrOp, DMWr, DMCtrl, RUWr, RUDATAWrSrc,
           Rs1, Rs2, Rd, Rs1Used, Rs2Used, BranchTaken,
    input  ExALUASrc, ExALUBSrc, ExALUOp, ExBrOp, MemDMWr, MemDMCtrl,
           WbRUWr, WbRUDATAWrSrc, WbRd, Stall, FlushIFID, ForwardA, ForwardB
  );
endinterface

// File: rtl/control_pipeline.sv
// Carries decoded control through ID/EX, EX/MEM and MEM/WB, and generates the stall, flush and forwarding selects.
// Latency: EX controls 1 cycle after ID, MEM after 2, WB after 3; the hazard outputs are combinational.
// Backpressure: Stall holds PC/IF-ID for one cycle on a load-use; BranchTaken flushes IF/ID and overrides Stall.
module control_pipeline #(
  parameter int REG_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  control_pipeline_if.slave cp
);

  localparam logic [1:0] WB_SRC_DMEM = 2'b01;
  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef struct packed {
    logic                alu_a_src;
    logic                alu_b_src;
    logic [3:0]          alu_op;
    logic [4:0]          br_op;
    logic                dm_wr;
    logic [2:0]          dm_ctrl;
    logic                ru_wr;
    logic [1:0]          wr_src;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic                dm_wr;
    logic [2:0]          dm_ctrl;
    logic                ru_wr;
    logic [1:0]          wr_src;
    logic [REG_BITS-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                ru_wr;
    logic [1:0]          wr_src;
    logic [REG_BITS-1:0] rd;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic load_use;
  logic stall;
  logic flush;

  // Load-use detection: a load in EX whose destination the ID instruction reads; x0 never counts.
  always_comb begin
    load_use = 1'b0;
    if (idex_q.ru_wr && (idex_q.wr_src == WB_SRC_DMEM) && (idex_q.rd != '0)) begin
      load_use = (cp.Rs1Used && (cp.Rs1 == idex_q.rd)) ||
                 (cp.Rs2Used && (cp.Rs2 == idex_q.rd));
    end
    // A taken branch makes the ID instruction wrong-path, so the flush suppresses the stall.
    flush = cp.BranchTaken;
    stall = load_use && !flush;
  end

  // Next-state for all three stage registers; a stall or flush inserts a bubble into ID/EX.
  always_comb begin
    idex_d.alu_a_src = cp.ALUASrc;
    idex_d.alu_b_src = cp.ALUBSrc;
    idex_d.alu_op    = cp.ALUOp;
    idex_d.br_op     = cp.BrOp;
    idex_d.dm_wr     = cp.DMWr;
    idex_d.dm_ctrl   = cp.DMCtrl;
    idex_d.ru_wr     = cp.RUWr;
    idex_d.wr_src    = cp.RUDATAWrSrc;
    idex_d.rs1       = cp.Rs1;
    idex_d.rs2       = cp.Rs2;
    idex_d.rd        = cp.Rd;
    if (stall || flush) begin
      idex_d = '0;
    end

    // The branching instruction itself moves on, so JAL/JALR still write their link register.
    exmem_d.dm_wr   = idex_q.dm_wr;
    exmem_d.dm_ctrl = idex_q.dm_ctrl;
    exmem_d.ru_wr   = idex_q.ru_wr;
    exmem_d.wr_src  = idex_q.wr_src;
    exmem_d.rd      = idex_q.rd;

    memwb_d.ru_wr  = exmem_q.ru_wr;
    memwb_d.wr_src = exmem_q.wr_src;
    memwb_d.rd     = exmem_q.rd;
  end

  // Stage registers; reset clears every stage to a bubble and beats any stall or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Operand forwarding for the EX instruction; the younger MEM result wins over WB.
  always_comb begin
    cp.ForwardA = FWD_REG;
    cp.ForwardB = FWD_REG;
    if (exmem_q.ru_wr && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1)) begin
      cp.ForwardA = FWD_MEM;
    end else if (memwb_q.ru_wr && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1)) begin
      cp.ForwardA = FWD_WB;
    end
    if (exmem_q.ru_wr && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2)) begin
      cp.ForwardB = FWD_MEM;
    end else if (memwb_q.ru_wr && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2)) begin
      cp.ForwardB = FWD_WB;
    end
  end

  // Stage controls straight from the registers, hazard controls from the combinational logic.
  always_comb begin
    cp.ExALUASrc     = idex_q.alu_a_src;
    cp.ExALUBSrc     = idex_q.alu_b_src;
    cp.ExALUOp       = idex_q.alu_op;
    cp.ExBrOp        = idex_q.br_op;
    cp.MemDMWr       = exmem_q.dm_wr;
    cp.MemDMCtrl     = exmem_q.dm_ctrl;
    cp.WbRUWr        = memwb_q.ru_wr;
    cp.WbRUDATAWrSrc = memwb_q.wr_src;
    cp.WbRd          = memwb_q.rd;
    cp.Stall         = stall;
    cp.FlushIFID     = flush;
  end

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: the stimulus drives one ID word per cycle and queues the expected outputs;
// a monitor pops the queue and compares on each falling edge.
// Covers reset, latency, load-use stall, forwarding priority, x0, branch flush, JAL writeback and reset mid-stall.
module tb_control_pipeline;

  logic clk;
  logic rst;

  control_pipeline_if #(.REG_BITS(5)) cp ();

  control_pipeline #(.REG_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .cp  (cp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       asrc;
    logic       bsrc;
    logic [3:0] aluop;
    logic [4:0] brop;
    logic       dmwr;
    logic [2:0] dmctrl;
    logic       ruwr;
    logic [1:0] wrsrc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
  } id_t;

  typedef struct {
    int          idx;
    logic [10:0] ex;
    logic [3:0]  mem;
    logic [7:0]  wb;
    logic [5:0]  haz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;
  logic stim_done = 1'b0;

  function automatic id_t nop();
    id_t w = '0;
    return w;
  endfunction

  function automatic id_t rty(logic [3:0] op, logic [4:0] s1, logic [4:0] s2, logic [4:0] d);
    id_t w = '0;
    w.aluop = op; w.ruwr = 1'b1; w.rs1 = s1; w.rs2 = s2; w.rd = d; w.u1 = 1'b1; w.u2 = 1'b1;
    return w;
  endfunction

  function automatic id_t ld(logic [4:0] s1, logic [4:0] d);
    id_t w = '0;
    w.bsrc = 1'b1; w.dmctrl = 3'b010; w.ruwr = 1'b1; w.wrsrc = 2'b01;
    w.rs1 = s1; w.rd = d; w.u1 = 1'b1;
    return w;
  endfunction

  function automatic id_t st(logic [4:0] d);
    id_t w = '0;
    w.bsrc = 1'b1; w.dmwr = 1'b1; w.dmctrl = 3'b010; w.rd = d; w.u1 = 1'b1; w.u2 = 1'b1;
    return w;
  endfunction

  function automatic id_t jal(logic [4:0] d);
    id_t w = '0;
    w.asrc = 1'b1; w.bsrc = 1'b1; w.brop = 5'b11000; w.ruwr = 1'b1; w.wrsrc = 2'b10; w.rd = d;
    return w;
  endfunction

  task automatic drive(input id_t w, input logic r, input logic b);
    rst            = r;
    cp.BranchTaken = b;
    cp.ALUASrc     = w.asrc;
    cp.ALUBSrc     = w.bsrc;
    cp.ALUOp       = w.aluop;
    cp.BrOp        = w.brop;
    cp.DMWr        = w.dmwr;
    cp.DMCtrl      = w.dmctrl;
    cp.RUWr        = w.ruwr;
    cp.RUDATAWrSrc = w.wrsrc;
    cp.Rs1         = w.rs1;
    cp.Rs2         = w.rs2;
    cp.Rd          = w.rd;
    cp.Rs1Used     = w.u1;
    cp.Rs2Used     = w.u2;
  endtask

  // ex = {asrc,bsrc,aluop,brop}  mem = {dmwr,dmctrl}  wb = {ruwr,wrsrc,rd}  haz = {stall,flush,fwdA,fwdB}
  task automatic step(input id_t w, input logic r, input logic b,
                      input logic [10:0] ex, input logic [3:0] mem,
                      input logic [7:0] wb, input logic [5:0] haz);
    exp_t e;
    @(posedge clk);
    #1;
    drive(w, r, b);
    e.idx = vec_idx; e.ex = ex; e.mem = mem; e.wb = wb; e.haz = haz;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, req);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex",  e.idx, {5'd0, cp.ExALUASrc, cp.ExALUBSrc, cp.ExALUOp, cp.ExBrOp}, {5'd0, e.ex});
        chk("mem", e.idx, {12'd0, cp.MemDMWr, cp.MemDMCtrl}, {12'd0, e.mem});
        chk("wb",  e.idx, {8'd0, cp.WbRUWr, cp.WbRUDATAWrSrc, cp.WbRd}, {8'd0, e.wb});
        chk("haz", e.idx, {10'd0, cp.Stall, cp.FlushIFID, cp.ForwardA, cp.ForwardB}, {10'd0, e.haz});
      end
    end
  end

  // Stimulus: one vector per cycle with hand-computed stage outputs
  initial begin
    drive(rty(4'b0001, 5'd1, 5'd2, 5'd5), 1'b1, 1'b0);
    // Reset held with live ID inputs, then latency of an R-type
    step(rty(4'b0001, 5'd1, 5'd2, 5'd5), 1, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0001, 5'd1, 5'd2, 5'd5), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0001_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_00101, 6'b0_0_00_00);
    // Load-use: load x7, dependent re-presented while stalled
    step(ld(5'd1, 5'd7), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0010, 5'd7, 5'd3, 5'd8), 0, 0, 11'b0_1_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b1_0_00_00);
    step(rty(4'b0010, 5'd7, 5'd3, 5'd8), 0, 0, 11'b0_0_0000_00000, 4'b0_010, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0010_00000, 4'b0_000, 8'b1_01_00111, 6'b0_0_10_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_01000, 6'b0_0_00_00);
    // Forward priority on x3: MEM over WB, then WB when MEM does not write
    step(rty(4'b0011, 5'd0, 5'd0, 5'd3), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0100, 5'd0, 5'd0, 5'd3), 0, 0, 11'b0_0_0011_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0101, 5'd0, 5'd3, 5'd9), 0, 0, 11'b0_0_0100_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0101_00000, 4'b0_000, 8'b1_00_00011, 6'b0_0_00_01);
    step(rty(4'b0011, 5'd0, 5'd0, 5'd3), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_00011, 6'b0_0_00_00);
    step(st(5'd3), 0, 0, 11'b0_0_0011_00000, 4'b0_000, 8'b1_00_01001, 6'b0_0_00_00);
    step(rty(4'b0110, 5'd0, 5'd3, 5'd10), 0, 0, 11'b0_1_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0110_00000, 4'b1_010, 8'b1_00_00011, 6'b0_0_00_10);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00011, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_01010, 6'b0_0_00_00);
    // x0: load to x0 then use of x0 -> no stall, no forward
    step(ld(5'd2, 5'd0), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0001, 5'd0, 5'd0, 5'd4), 0, 0, 11'b0_1_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0001_00000, 4'b0_010, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_01_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_00100, 6'b0_0_00_00);
    // Branch taken while a load-use dependent sits in ID: flush wins
    step(ld(5'd1, 5'd7), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0010, 5'd7, 5'd0, 5'd8), 0, 1, 11'b0_1_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_1_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_010, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_01_00111, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    // JAL x1 resolves taken in EX; its link write survives to WB and forwards
    step(jal(5'd1), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(rty(4'b0111, 5'd2, 5'd3, 5'd11), 0, 1, 11'b1_1_0000_11000, 4'b0_000, 8'b0_00_00000, 6'b0_1_00_00);
    step(rty(4'b0001, 5'd1, 5'd0, 5'd2), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0001_00000, 4'b0_000, 8'b1_10_00001, 6'b0_0_10_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    // Reset asserted in the same cycle as a stall
    step(ld(5'd1, 5'd7), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_00010, 6'b0_0_00_00);
    step(rty(4'b0010, 5'd7, 5'd0, 5'd8), 1, 0, 11'b0_1_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b1_0_00_00);
    step(rty(4'b0010, 5'd7, 5'd0, 5'd8), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0010_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b0_00_00000, 6'b0_0_00_00);
    step(nop(), 0, 0, 11'b0_0_0000_00000, 4'b0_000, 8'b1_00_01000, 6'b0_0_00_00);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    if (!stim_done) begin
      $display("FAIL watchdog: stimulus incomplete at vec %0d, expected %0d vectors", vec_idx, 42);
      $fatal(1, "timeout");
    end
  end

endmodule
